commit_monitor: RTL and testbench

COMMIT_MONITOR -- requirements
Module: commit_monitor

---
 rtl/npc_pkg.sv | 32 +++
 rtl/commit_fifo.sv | 57 +++++
 rtl/commit_monitor.sv | 132 +++++++++++++
 tb/tb_commit_monitor.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Shared definitions for the commit monitor: the ebreak encoding, the run-status
// encoding, the monitor FSM states and the layout of one trace entry.
package npc_pkg;

    localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

    // pc + instr + wdata + rd + wen
    localparam int PAYLOAD_W = 101;

    typedef enum logic [1:0] {
        STATUS_RUNNING = 2'b00,
        STATUS_GOOD    = 2'b01,
        STATUS_BAD     = 2'b10,
        STATUS_TIMEOUT = 2'b11
    } status_e;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DONE,
        ST_TIMEOUT
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] wdata;
        logic [3:0]  rd;
        logic        wen;
    } commit_entry_t;

endpackage

// File: rtl/commit_fifo.sv
// Synchronous trace FIFO. A push becomes visible on the read side one cycle
// later (no bypass). The read port shows zero while empty so the consumer
// never sees stale entries after reset.
module commit_fifo
    import npc_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [PAYLOAD_W-1:0] wr_data,
    output logic [PAYLOAD_W-1:0] rd_data,
    output logic                 empty,
    output logic                 full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [PAYLOAD_W-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;
    logic                 push_ok;
    logic                 pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the read port is gated by empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/commit_monitor.sv
// Commit monitor: buffers retired instructions for a difftest consumer,
// watches for ebreak to decide the run outcome, and enforces a cycle budget.
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   ST_RUN     | accepting retirements into the trace FIFO, counting cycles
//   ST_DRAIN   | ebreak accepted, core stalled, waiting for FIFO to empty
//   ST_DONE    | trace drained, outcome (good/bad trap) reported, terminal
//   ST_TIMEOUT | cycle budget exhausted before ebreak, terminal
module commit_monitor
    import npc_pkg::*;
#(
    parameter int          DEPTH      = 8,
    parameter int unsigned MAX_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cm_valid,
    input  logic [31:0] cm_pc,
    input  logic [31:0] cm_instr,
    input  logic        cm_wen,
    input  logic [3:0]  cm_rd,
    input  logic [31:0] cm_wdata,
    input  logic [31:0] cm_a0,
    output logic        cm_stall,
    output logic        tr_valid,
    input  logic        tr_ready,
    output logic [31:0] tr_pc,
    output logic [31:0] tr_instr,
    output logic [31:0] tr_wdata,
    output logic [3:0]  tr_rd,
    output logic        tr_wen,
    output logic        done,
    output logic [1:0]  status,
    output logic [31:0] cycles
);

    localparam logic [31:0] MAX_CYC = 32'(MAX_CYCLES);

    state_e               state_q;
    state_e               state_d;
    logic [31:0]          cycles_q;
    logic                 bad_q;
    logic                 latch_outcome;
    status_e              status_d;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic                 timeout_hit;
    logic                 is_ebreak;
    commit_entry_t        wr_entry;
    logic [PAYLOAD_W-1:0] rd_data;

    assign cm_stall    = fifo_full | (state_q != ST_RUN);
    assign push        = cm_valid & ~cm_stall;
    assign pop         = tr_valid & tr_ready;
    assign tr_valid    = ~fifo_empty;
    assign is_ebreak   = (cm_instr == EBREAK_INSTR);
    assign timeout_hit = (cycles_q == MAX_CYC);
    assign cycles      = cycles_q;
    assign status      = status_d;

    assign wr_entry = '{pc: cm_pc, instr: cm_instr, wdata: cm_wdata, rd: cm_rd, wen: cm_wen};
    assign {tr_pc, tr_instr, tr_wdata, tr_rd, tr_wen} = rd_data;

    commit_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_entry),
        .rd_data (rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_RUN;
        else      state_q <= state_d;
    end

    // Next state and run outputs; timeout takes priority over a same-cycle ebreak.
    always_comb begin
        state_d       = state_q;
        latch_outcome = 1'b0;
        done          = 1'b0;
        status_d      = STATUS_RUNNING;
        case (state_q)
            ST_RUN: begin
                if (timeout_hit) begin
                    state_d = ST_TIMEOUT;
                end else if (push && is_ebreak) begin
                    state_d       = ST_DRAIN;
                    latch_outcome = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) state_d = ST_DONE;
            end
            ST_DONE: begin
                done     = 1'b1;
                status_d = bad_q ? STATUS_BAD : STATUS_GOOD;
            end
            ST_TIMEOUT: begin
                done     = 1'b1;
                status_d = STATUS_TIMEOUT;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Outcome of the run, captured when the ebreak entry is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)               bad_q <= 1'b0;
        else if (latch_outcome) bad_q <= (cm_a0 != 32'd0);
    end

    // Saturating cycle counter; holds on the cycle that triggers the timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycles_q <= '0;
        end else if (((state_q == ST_RUN && !timeout_hit) || state_q == ST_DRAIN)
                     && cycles_q != '1) begin
            cycles_q <= cycles_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_commit_monitor.sv
// Directed bench for commit_monitor. Main instance uses a long cycle budget;
// a second instance with a 20-cycle budget covers the timeout path.
module tb_commit_monitor;

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cm_valid = 1'b0;
    logic [31:0] cm_pc = '0;
    logic [31:0] cm_instr = '0;
    logic        cm_wen = 1'b0;
    logic [3:0]  cm_rd = '0;
    logic [31:0] cm_wdata = '0;
    logic [31:0] cm_a0 = '0;
    logic        tr_ready = 1'b0;

    logic        cm_stall, tr_valid, tr_wen, done;
    logic [31:0] tr_pc, tr_instr, tr_wdata, cycles;
    logic [3:0]  tr_rd;
    logic [1:0]  status;

    logic        to_stall, to_trv, to_wen, to_done;
    logic [31:0] to_pc, to_instr, to_wdata, to_cycles;
    logic [3:0]  to_rd;
    logic [1:0]  to_status;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    commit_monitor #(.DEPTH(8), .MAX_CYCLES(1000)) dut (
        .clk(clk), .rst(rst),
        .cm_valid(cm_valid), .cm_pc(cm_pc), .cm_instr(cm_instr), .cm_wen(cm_wen),
        .cm_rd(cm_rd), .cm_wdata(cm_wdata), .cm_a0(cm_a0), .cm_stall(cm_stall),
        .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_pc(tr_pc), .tr_instr(tr_instr),
        .tr_wdata(tr_wdata), .tr_rd(tr_rd), .tr_wen(tr_wen),
        .done(done), .status(status), .cycles(cycles)
    );

    commit_monitor #(.DEPTH(8), .MAX_CYCLES(20)) dut_to (
        .clk(clk), .rst(rst),
        .cm_valid(cm_valid), .cm_pc(cm_pc), .cm_instr(cm_instr), .cm_wen(cm_wen),
        .cm_rd(cm_rd), .cm_wdata(cm_wdata), .cm_a0(cm_a0), .cm_stall(to_stall),
        .tr_valid(to_trv), .tr_ready(tr_ready), .tr_pc(to_pc), .tr_instr(to_instr),
        .tr_wdata(to_wdata), .tr_rd(to_rd), .tr_wen(to_wen),
        .done(to_done), .status(to_status), .cycles(to_cycles)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Entry i as {pc, instr, wdata, rd, wen}; instr is an addi, never ebreak.
    function automatic logic [100:0] ent(input int i);
        logic [31:0] pc, instr, wdata;
        logic [3:0]  rd;
        logic        wen;
        pc    = 32'h8000_0000 + 32'(i * 4);
        instr = 32'h0000_0013 | (32'(i) << 20);
        wdata = 32'hA5A5_0000 + 32'(i);
        rd    = 4'(i + 1);
        wen   = i[0];
        return {pc, instr, wdata, rd, wen};
    endfunction

    function automatic logic [100:0] head();
        return {tr_pc, tr_instr, tr_wdata, tr_rd, tr_wen};
    endfunction

    function automatic logic [100:0] head_to();
        return {to_pc, to_instr, to_wdata, to_rd, to_wen};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_entry(input int i);
        {cm_pc, cm_instr, cm_wdata, cm_rd, cm_wen} = ent(i);
        cm_valid = 1'b1;
    endtask

    task automatic drive_ebreak(input logic [31:0] a0);
        cm_pc    = 32'h8000_0100;
        cm_instr = EBREAK;
        cm_wdata = '0;
        cm_rd    = '0;
        cm_wen   = 1'b0;
        cm_a0    = a0;
        cm_valid = 1'b1;
    endtask

    // Leaves rst=1 just after an edge, so the next edge is the first count.
    task automatic do_reset();
        rst      = 1'b0;
        cm_valid = 1'b0;
        tr_ready = 1'b0;
        cm_a0    = '0;
        step();
        step();
        rst = 1'b1;
    endtask

    // Consume n entries expected as ent(first)..ent(first+n-1), bounded in cycles.
    task automatic drain_expect(input int first, input int n);
        int  rx;
        logic pop_now, push_now;
        rx = 0;
        tr_ready = 1'b1;
        for (int c = 0; c < 60 && rx < n; c++) begin
            pop_now  = tr_valid;
            push_now = cm_valid && !cm_stall;
            if (tr_valid) chk("drain_data", 128'(head()), 128'(ent(first + rx)));
            step();
            if (pop_now)  rx++;
            if (push_now) cm_valid = 1'b0;
        end
        chk("drain_count", 128'(rx), 128'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        // Reset values and basic 1-cycle latency streaming.
        do_reset();
        chk("rst_trv",    128'(tr_valid), 128'(0));
        chk("rst_stall",  128'(cm_stall), 128'(0));
        chk("rst_done",   128'(done),     128'(0));
        chk("rst_status", 128'(status),   128'(0));
        chk("rst_cycles", 128'(cycles),   128'(0));
        chk("rst_head",   128'(head()),   128'(0));
        tr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_entry(i);
            step();
            chk("stream_trv",  128'(tr_valid), 128'(1));
            chk("stream_head", 128'(head()),   128'(ent(i)));
        end
        cm_valid = 1'b0;
        step();
        chk("stream_empty",  128'(tr_valid), 128'(0));
        chk("stream_cycles", 128'(cycles),   128'(4));

        // Fill to DEPTH with consumer blocked, hold a 9th, then drain all 9.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive_entry(i);
            if (i == 7) chk("fill_stall7", 128'(cm_stall), 128'(0));
            step();
        end
        chk("full_stall", 128'(cm_stall), 128'(1));
        chk("full_head",  128'(head()),   128'(ent(0)));
        drive_entry(8);
        step();
        step();
        chk("hold_stall", 128'(cm_stall), 128'(1));
        chk("hold_head",  128'(head()),   128'(ent(0)));
        drain_expect(0, 9);
        chk("fill_empty", 128'(tr_valid), 128'(0));

        // Good trap: two entries queued ahead of ebreak with a0=0.
        do_reset();
        drive_entry(0);
        step();
        drive_entry(1);
        step();
        drive_ebreak(32'd0);
        step();
        cm_valid = 1'b0;
        chk("good_drain_status", 128'(status),   128'(0));
        chk("good_drain_done",   128'(done),     128'(0));
        chk("good_drain_stall",  128'(cm_stall), 128'(1));
        tr_ready = 1'b1;
        step();
        step();
        chk("good_ebreak_head", 128'(tr_instr), 128'(EBREAK));
        chk("good_mid_status",  128'(status),   128'(0));
        step();
        chk("good_empty_trv",  128'(tr_valid), 128'(0));
        chk("good_empty_done", 128'(done),     128'(0));
        step();
        chk("good_done",   128'(done),   128'(1));
        chk("good_status", 128'(status), 128'(1));

        // Bad trap: a0=1, then further retirements are refused.
        do_reset();
        tr_ready = 1'b1;
        drive_ebreak(32'd1);
        step();
        cm_valid = 1'b0;
        chk("bad_drain_status", 128'(status), 128'(0));
        step();
        step();
        chk("bad_done",   128'(done),   128'(1));
        chk("bad_status", 128'(status), 128'(2));
        chk("bad_cycles", 128'(cycles), 128'(3));
        drive_entry(5);
        chk("bad_stall", 128'(cm_stall), 128'(1));
        step();
        step();
        cm_valid = 1'b0;
        chk("bad_ignored",     128'(tr_valid), 128'(0));
        chk("bad_done_hold",   128'(done),     128'(1));
        chk("bad_status_hold", 128'(status),   128'(2));
        chk("bad_cycles_hold", 128'(cycles),   128'(3));

        // Timeout at 20 cycles; an ebreak in the same cycle loses to the timeout.
        do_reset();
        tr_ready = 1'b1;
        repeat (20) step();
        chk("to_cycles20", 128'(to_cycles), 128'(20));
        chk("to_pre_done", 128'(to_done),   128'(0));
        chk("to_pre_stat", 128'(to_status), 128'(0));
        drive_ebreak(32'd0);
        chk("to_pre_stall", 128'(to_stall), 128'(0));
        step();
        cm_valid = 1'b0;
        chk("to_done",   128'(to_done),   128'(1));
        chk("to_status", 128'(to_status), 128'(3));
        chk("to_cycles", 128'(to_cycles), 128'(20));
        chk("to_head",   128'(head_to()),
            128'({32'h8000_0100, EBREAK, 32'd0, 4'd0, 1'b0}));
        repeat (9) step();
        chk("to_cycles_frozen", 128'(to_cycles), 128'(20));
        chk("to_status_hold",   128'(to_status), 128'(3));
        chk("to_stall_hold",    128'(to_stall),  128'(1));
        chk("to_drained",       128'(to_trv),    128'(0));

        // Asynchronous reset with entries queued.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_entry(i);
            step();
        end
        cm_valid = 1'b0;
        chk("async_pre_trv",    128'(tr_valid), 128'(1));
        chk("async_pre_cycles", 128'(cycles),   128'(4));
        #2;
        rst = 1'b0;
        #1;
        chk("async_trv",    128'(tr_valid), 128'(0));
        chk("async_cycles", 128'(cycles),   128'(0));
        chk("async_status", 128'(status),   128'(0));
        chk("async_head",   128'(head()),   128'(0));
        chk("async_stall",  128'(cm_stall), 128'(0));
        do_reset();
        step();
        chk("async_post_trv",    128'(tr_valid), 128'(0));
        chk("async_post_cycles", 128'(cycles),   128'(1));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
